uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between NUM_REQ byte-stream requesters.
- Grants whole frames (byte runs terminated by a last flag) to requesters in round-robin order, then forwards the granted stream to the transmitter's valid/ready input.
- A stall timeout releases the grant if a requester goes silent mid-frame.
- Sits between on-chip status/telemetry sources and the single test-harness UART TX.

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte-stream requesters, the arbiter and the UART transmitter.
// master: arbiter side; slave: requester/transmitter environment side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_valid;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_ready;
  logic [NUM_REQ-1:0]           grant;
  logic                         busy;
  logic                         timeout_err;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant, busy, timeout_err
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter sharing one UART TX among NUM_REQ byte streams, with stall timeout.
// Define UART_TX_ARBITER_HEADER_EN to prefix every granted frame with a requester-id header byte.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input logic               clk,
  input logic               n_reset,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (TIMEOUT_CLKS == 0) ? 1 : $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CntW-1:0] CntLast = (TIMEOUT_CLKS == 0) ? '0 : CntW'(TIMEOUT_CLKS - 1);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NUM_REQ - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StPass   = 2'd2;
`ifdef UART_TX_ARBITER_HEADER_EN
  localparam logic [1:0] StHeader = 2'd1;
`endif

  logic [1:0]           state_q, state_d;
  logic [PtrW-1:0]      gnt_idx_q, gnt_idx_d;
  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
  logic [PtrW-1:0]      sel_idx, gnt_next;
  logic [PtrW:0]        cand;
  logic                 sel_found;
  logic                 g_valid, g_last, xfer;
  logic [DATA_BITS-1:0] g_data;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
      if (cand >= (PtrW+1)'(NUM_REQ)) cand = cand - (PtrW+1)'(NUM_REQ);
      if (!sel_found && bus.req_valid[cand[PtrW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PtrW-1:0];
      end
    end
  end

  assign g_valid  = bus.req_valid[gnt_idx_q];
  assign g_last   = bus.req_last[gnt_idx_q];
  assign g_data   = bus.req_data[gnt_idx_q*DATA_BITS +: DATA_BITS];
  assign gnt_next = (gnt_idx_q == PtrLast) ? '0 : gnt_idx_q + 1'b1;

  always_comb begin
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.req_ready = '0;
    case (state_q)
      StPass: begin
        bus.tx_valid             = g_valid;
        bus.tx_data              = g_data;
        bus.req_ready[gnt_idx_q] = bus.tx_ready;
      end
`ifdef UART_TX_ARBITER_HEADER_EN
      // Upper half all ones, requester index zero-extended into the lower half (0xF2 for id 2).
      StHeader: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = {{(DATA_BITS - DATA_BITS/2){1'b1}}, (DATA_BITS/2)'(gnt_idx_q)};
      end
`endif
      default: ;
    endcase
  end

  assign xfer            = bus.tx_valid && bus.tx_ready;
  assign bus.grant       = (state_q == StIdle) ? '0 : (NUM_REQ'(1) << gnt_idx_q);
  assign bus.busy        = (state_q != StIdle);
  assign bus.timeout_err = tmo_q;

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    tmo_d     = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (sel_found) begin
          gnt_idx_d = sel_idx;
`ifdef UART_TX_ARBITER_HEADER_EN
          state_d   = StHeader;
`else
          state_d   = StPass;
`endif
        end
      end
`ifdef UART_TX_ARBITER_HEADER_EN
      StHeader: begin
        if (xfer) begin
          state_d = StPass;
          cnt_d   = '0;
        end
      end
`endif
      StPass: begin
        if (xfer) begin
          cnt_d = '0;
          if (g_last) begin
            state_d  = StIdle;
            rr_ptr_d = gnt_next;
          end
        end else if (TIMEOUT_CLKS != 0 && !g_valid) begin
          // Only requester silence counts; downstream backpressure holds the count.
          if (cnt_q == CntLast) begin
            tmo_d    = 1'b1;
            state_d  = StIdle;
            rr_ptr_d = gnt_next;
            cnt_d    = '0;
          end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= StIdle;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed frames per requester, expected byte/grant
// order pushed by the stimulus and popped by an independent transfer monitor.
module tb_uart_tx_arbiter;
  localparam int unsigned NR  = 4;
  localparam int unsigned DB  = 8;
  localparam int unsigned TMO = 4;

  logic clk     = 1'b0;
  logic n_reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_BITS(DB)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .DATA_BITS   (DB),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .bus    (bus)
  );

  logic [7:0]  src_data [NR][16];
  logic        src_last [NR][16];
  int          src_len  [NR];
  int          src_pos  [NR];
  logic [11:0] exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Each requester presents its next queued byte until it is accepted.
  always_comb begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NR; i++) begin
      if (src_pos[i] < src_len[i]) begin
        bus.req_valid[i]         = 1'b1;
        bus.req_last[i]          = src_last[i][src_pos[i]];
        bus.req_data[i*DB +: DB] = src_data[i][src_pos[i]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic load(input int r, input logic [7:0] base, input int n, input bit last);
    for (int k = 0; k < n; k++) begin
      src_data[r][src_len[r]] = base + 8'(k);
      src_last[r][src_len[r]] = last && (k == n - 1);
      src_len[r]++;
    end
  endtask

  task automatic expect_frame(input int g, input logic [7:0] base, input int n);
`ifdef UART_TX_ARBITER_HEADER_EN
    exp_q.push_back({4'(1 << g), 8'hF0 | 8'(g)});
`endif
    for (int k = 0; k < n; k++) exp_q.push_back({4'(1 << g), base + 8'(k)});
  endtask

  task automatic run_sources();
    logic [NR-1:0] f;
    forever begin
      @(negedge clk);
      f = bus.req_valid & bus.req_ready;
      @(posedge clk);
      for (int i = 0; i < NR; i++) if (f[i]) src_pos[i] <= src_pos[i] + 1;
    end
  endtask

  task automatic run_monitor();
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (n_reset && bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL tx_unexpected: got grant %b byte %h, required no transfer",
                   bus.grant, bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_grant_byte", 32'({bus.grant, bus.tx_data}), 32'(e));
        end
      end
    end
  endtask

  task automatic wait_done(input string name, input int maxc);
    int c = 0;
    while (!(exp_q.size() == 0 && !bus.busy) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_done"}, 32'(c < maxc), 32'd1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    int rises, idles, bad, tmo, c;
    bit prev, started;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    fork
      run_monitor();
      run_sources();
      begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1);
      end
    join_none

    #1 n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    n_reset = 1'b1;
    @(posedge clk);
    #2;

    // All four requesters at once: frames served 0,1,2,3 with one idle cycle between.
    bus.tx_ready = 1'b1;
    for (int g = 0; g < NR; g++) begin
      load(g, 8'hA0 + 8'(g * 16), 3, 1'b1);
      expect_frame(g, 8'hA0 + 8'(g * 16), 3);
    end
    rises = 0;
    idles = 0;
    prev  = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.busy && !prev) rises++;
      if (!bus.busy && rises > 0 && exp_q.size() > 0) idles++;
      prev = bus.busy;
      if (exp_q.size() == 0 && !bus.busy) break;
    end
    chk("simul_frames", 32'(rises), 32'd4);
    chk("simul_idle_gaps", 32'(idles), 32'd3);
    wait_done("simul", 50);

    // Backpressure: tx_ready toggles; grant held, no timeout.
    load(1, 8'h50, 5, 1'b1);
    expect_frame(1, 8'h50, 5);
    bad = 0;
    tmo = 0;
    started = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #2;
      bus.tx_ready = ~bus.tx_ready;
      @(negedge clk);
      if (bus.busy) begin
        started = 1'b1;
        if (bus.grant !== 4'b0010) bad++;
      end
      if (bus.timeout_err) tmo++;
      if (started && !bus.busy && exp_q.size() == 0) break;
    end
    chk("bp_grant_held", 32'(bad), 32'd0);
    chk("bp_no_timeout", 32'(tmo), 32'd0);
    @(posedge clk);
    #2;
    bus.tx_ready = 1'b1;
    wait_done("backpressure", 50);

    // Reset mid-frame with requester 1 granted; rr_ptr must return to 0.
    bus.tx_ready = 1'b0;
    load(1, 8'h10, 4, 1'b1);
    c = 0;
    while (bus.grant !== 4'b0010 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("rstmid_pre_grant", 32'(bus.grant), 32'h2);
    @(posedge clk);
    #3;
    n_reset = 1'b0;
    #1;
    chk("rstmid_grant", 32'(bus.grant), 32'd0);
    chk("rstmid_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rstmid_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    src_len[1] = src_pos[1];
    @(posedge clk);
    #2;
    n_reset = 1'b1;
    bus.tx_ready = 1'b1;
    load(0, 8'h0E, 1, 1'b1);
    load(3, 8'h3E, 1, 1'b1);
    expect_frame(0, 8'h0E, 1);
    expect_frame(3, 8'h3E, 1);
    wait_done("rstmid_rr", 50);

    // Fairness: requester 0 back-to-back against requester 3.
    load(0, 8'h01, 2, 1'b1);
    load(0, 8'h03, 2, 1'b1);
    load(3, 8'h31, 1, 1'b1);
    load(3, 8'h32, 1, 1'b1);
    expect_frame(0, 8'h01, 2);
    expect_frame(3, 8'h31, 1);
    expect_frame(0, 8'h03, 2);
    expect_frame(3, 8'h32, 1);
    wait_done("fair", 100);

    // Stall timeout: requester 2 goes silent mid-frame, requester 3 waiting.
    load(2, 8'h2A, 1, 1'b0);
    load(3, 8'h3C, 1, 1'b1);
    expect_frame(2, 8'h2A, 1);
    expect_frame(3, 8'h3C, 1);
    c = 0;
    while (!(bus.tx_valid && bus.tx_ready && bus.tx_data == 8'h2A && bus.grant == 4'b0100)
           && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk("tmo_last_xfer_seen", 32'(c < 30), 32'd1);
    repeat (4) @(negedge clk);
    chk("tmo_grant_held", 32'(bus.grant), 32'h4);
    chk("tmo_no_early_pulse", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    chk("tmo_release", 32'(bus.grant), 32'd0);
    chk("tmo_pulse", 32'(bus.timeout_err), 32'd1);
    @(negedge clk);
    chk("tmo_pulse_once", 32'(bus.timeout_err), 32'd0);
    chk("tmo_next_grant", 32'(bus.grant), 32'h8);
    wait_done("timeout", 50);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
